i2s_mic_rx: RTL and testbench

- I2S receiver for the SoM's MEMS microphone.
- Generates mic_clk and mic_ws from the 48 MHz system clock and deserialises mic_dout.
- Presents one parallel PCM sample per captured slot on a valid/ready stream, for downstream audio buffering or feature logic.
- Replaces the free-running mic_clk/mic_ws divider taps in the top level.

---
 rtl/i2s_mic_rx.sv | 136 +++++++++++++
 tb/tb_i2s_mic_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// I2S receiver for a MEMS microphone: generates bit clock and word select from clk,
// deserialises mic_dout and hands each captured slot out on a valid/ready stream.
module i2s_mic_rx #(
  parameter int CLK_DIV     = 8,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 18,
  parameter int CHANNEL     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   mic_clk,
  output logic                   mic_ws,
  input  logic                   mic_dout,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_LEN   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] LAST_POS   = BW'(SAMPLE_BITS);

  logic [DW-1:0]          div_q, div_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] data_q, data_d;
  logic                   right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic          div_wrap;
  logic          slot_right;
  logic          chan_ok;
  logic [BW-1:0] pos;
  logic          capture;
  logic          complete;

  always_comb begin
    div_wrap   = (div_q == DIV_LAST);
    slot_right = (bit_q >= SLOT_LEN);
    pos        = slot_right ? (bit_q - SLOT_LEN) : bit_q;
    chan_ok    = (CHANNEL == 2) || ((CHANNEL == 1) == slot_right);
    // Sample on the last high-phase cycle; the mic launched this bit on our previous fall.
    capture    = enable && sck_q && div_wrap && chan_ok &&
                 (pos != '0) && (pos <= LAST_POS);
    complete   = capture && (pos == LAST_POS);

    div_d   = div_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    right_d = right_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (!enable) begin
      div_d   = '0;
      sck_d   = 1'b0;
      ws_d    = 1'b0;
      bit_d   = '0;
      shift_d = '0;
    end else begin
      if (div_wrap) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (sck_q) begin
          bit_d = (bit_q == FRAME_LAST) ? '0 : bit_q + 1'b1;
          ws_d  = (bit_d >= SLOT_LEN);
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      if (capture) begin
        shift_d    = shift_q << 1;
        shift_d[0] = mic_dout;
      end
    end

    if (valid_q && sample_ready) valid_d = 1'b0;
    if (clear_ovf) ovf_d = 1'b0;
    // A transfer on the completion cycle frees the register for the new sample.
    if (complete) begin
      if (!valid_q || sample_ready) begin
        data_d  = shift_d;
        right_d = slot_right;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      right_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mic_clk      = sck_q;
  assign mic_ws       = ws_q;
  assign sample_data  = data_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a left-only and a stereo instance, each fed by a mic model
// that queues the expected sample when it drives the last bit of a slot.
module tb_i2s_mic_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset0, enable0, ready0, clr0, dout0;
  logic mic_clk0, mic_ws0, right0, valid0, ovf0;
  logic [17:0] data0;
  logic reset_st, enable_st, ready_st, clr_st, dout_st;
  logic mic_clk_st, mic_ws_st, right_st, valid_st, ovf_st;
  logic [17:0] data_st;

  i2s_mic_rx #(.CLK_DIV(8), .SLOT_BITS(32), .SAMPLE_BITS(18), .CHANNEL(0)) dut (
    .clk(clk), .reset(reset0), .enable(enable0), .mic_clk(mic_clk0), .mic_ws(mic_ws0),
    .mic_dout(dout0), .sample_data(data0), .sample_right(right0), .sample_valid(valid0),
    .sample_ready(ready0), .overflow(ovf0), .clear_ovf(clr0));

  i2s_mic_rx #(.CLK_DIV(8), .SLOT_BITS(32), .SAMPLE_BITS(18), .CHANNEL(2)) dut_st (
    .clk(clk), .reset(reset_st), .enable(enable_st), .mic_clk(mic_clk_st), .mic_ws(mic_ws_st),
    .mic_dout(dout_st), .sample_data(data_st), .sample_right(right_st), .sample_valid(valid_st),
    .sample_ready(ready_st), .overflow(ovf_st), .clear_ovf(clr_st));

  int n_pass = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  logic [18:0] q0[$];
  logic [18:0] qst[$];
  logic [18:0] e0, est;
  int pops0 = 0, pops_st = 0, last_st = -1;
  bit auto0 = 1'b1;

  // Mic models: launch the next bit on each falling bit clock, MSB one bit after ws edge.
  logic [17:0] w0_l, w0_r, wst_l, wst_r, word0, word_st;
  int idx0, idx_st;
  logic pws0, pclk0, pws_st, pclk_st;

  always @(posedge clk) begin
    #1;
    if (reset0 || !enable0) begin
      idx0 = 0; pws0 = 1'b0; pclk0 = 1'b0; dout0 = 1'b1;
    end else begin
      if (pclk0 && !mic_clk0) begin
        if (mic_ws0 != pws0) idx0 = 0; else idx0++;
        pws0 = mic_ws0;
        word0 = mic_ws0 ? w0_r : w0_l;
        if (idx0 >= 1 && idx0 <= 18) begin
          dout0 = word0[18 - idx0];
          if (idx0 == 18 && !mic_ws0 && auto0) q0.push_back({1'b0, word0});
        end else dout0 = 1'b1;
      end
      pclk0 = mic_clk0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_st || !enable_st) begin
      idx_st = 0; pws_st = 1'b0; pclk_st = 1'b0; dout_st = 1'b1;
    end else begin
      if (pclk_st && !mic_clk_st) begin
        if (mic_ws_st != pws_st) idx_st = 0; else idx_st++;
        pws_st = mic_ws_st;
        word_st = mic_ws_st ? wst_r : wst_l;
        if (idx_st >= 1 && idx_st <= 18) begin
          dout_st = word_st[18 - idx_st];
          if (idx_st == 18) qst.push_back({mic_ws_st, word_st});
        end else dout_st = 1'b1;
      end
      pclk_st = mic_clk_st;
    end
  end

  always @(negedge clk) begin
    if (valid0 && ready0) begin
      check_eq("sb0_empty", 32'(q0.size() == 0), 32'd0);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check_eq("sb0_sample", {13'd0, right0, data0}, {13'd0, e0});
        $display("dut0 sample right=%0d data=%05h", right0, data0);
      end
      pops0++;
    end
  end

  always @(negedge clk) begin
    if (valid_st && ready_st) begin
      check_eq("st_empty", 32'(qst.size() == 0), 32'd0);
      if (qst.size() != 0) begin
        est = qst.pop_front();
        check_eq("st_sample", {13'd0, right_st, data_st}, {13'd0, est});
        $display("stereo sample right=%0d data=%05h", right_st, data_st);
      end
      if (last_st >= 0) check_eq("st_gap", 32'(cyc - last_st), 32'd512);
      last_st = cyc;
      pops_st++;
    end
  end

  initial begin
    int n, r, c0, p;
    reset0 = 1'b1; reset_st = 1'b1; enable0 = 1'b1; enable_st = 1'b1;
    ready0 = 1'b1; ready_st = 1'b1; clr0 = 1'b0; clr_st = 1'b0;
    w0_l = 18'h2A5C3; w0_r = 18'h15A3C; wst_l = 18'h00001; wst_r = 18'h3FFFF;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mic_clk", 32'(mic_clk0), 32'd0);
    check_eq("rst_mic_ws", 32'(mic_ws0), 32'd0);
    check_eq("rst_data", 32'(data0), 32'd0);
    check_eq("rst_right", 32'(right0), 32'd0);
    check_eq("rst_valid", 32'(valid0), 32'd0);
    check_eq("rst_ovf", 32'(ovf0), 32'd0);
    c0 = cyc;
    #1; reset0 = 1'b0; reset_st = 1'b0;

    repeat (7) @(posedge clk);
    #1; check_eq("first_rise_early", 32'(mic_clk0), 32'd0);
    @(posedge clk); #1; check_eq("first_rise", 32'(mic_clk0), 32'd1);
    r = cyc;
    n = 0; while (mic_clk0 && n < 100) begin @(posedge clk); #1; n++; end
    n = 0; while (!mic_clk0 && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("sck_period", 32'(cyc - r), 32'd16);
    n = 0; while (!mic_ws0 && n < 1100) begin @(posedge clk); #1; n++; end
    check_eq("ws_rise", 32'(cyc - c0), 32'd512);
    r = cyc;
    n = 0; while (mic_ws0 && n < 1100) begin @(posedge clk); #1; n++; end
    check_eq("ws_half_frame", 32'(cyc - r), 32'd512);
    #1;

    // Left-only capture over several frames; right slot must never appear.
    n = 0; while (pops0 < 3 && n < 2500) begin @(posedge clk); #2; n++; end
    check_eq("cap_count", 32'(pops0), 32'd3);
    check_eq("cap_q_empty", 32'(q0.size()), 32'd0);

    // Backpressure: hold one, drop the next, clear coinciding with a drop.
    n = 0; while (!valid0 && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("bp_sync", 32'(valid0), 32'd1);
    @(posedge clk); #2;
    ready0 = 1'b0; auto0 = 1'b0; w0_l = 18'h12345; q0.push_back({1'b0, 18'h12345});
    n = 0; while (!valid0 && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("bp_load", 32'(valid0), 32'd1);
    check_eq("bp_data", 32'(data0), 32'h12345);
    w0_l = 18'h3ABCD;
    n = 0; while (!ovf0 && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("bp_ovf", 32'(ovf0), 32'd1);
    check_eq("bp_hold", 32'(data0), 32'h12345);
    check_eq("bp_valid_hold", 32'(valid0), 32'd1);
    w0_l = 18'h0F0F0;
    repeat (1023) @(posedge clk);
    #2; clr0 = 1'b1;
    @(posedge clk); #1;
    check_eq("ovf_set_wins", 32'(ovf0), 32'd1);
    check_eq("bp_hold2", 32'(data0), 32'h12345);
    clr0 = 1'b0;
    #1;
    @(posedge clk); #2; clr0 = 1'b1;
    @(posedge clk); #1; clr0 = 1'b0;
    check_eq("ovf_clear", 32'(ovf0), 32'd0);
    w0_l = 18'h25A5A; q0.push_back({1'b0, 18'h25A5A});
    #1;
    repeat (1021) @(posedge clk);
    #2; ready0 = 1'b1;
    @(posedge clk); #1;
    check_eq("rdy_no_ovf", 32'(ovf0), 32'd0);
    check_eq("rdy_load", 32'(valid0), 32'd1);
    check_eq("rdy_data", 32'(data0), 32'h25A5A);
    auto0 = 1'b1;
    #1;
    n = 0; while (q0.size() != 0 && n < 10) begin @(posedge clk); #2; n++; end
    check_eq("bp_drain", 32'(q0.size()), 32'd0);

    // Enable abort during the high phase of left-slot bit 9.
    n = 0; while (!(idx0 == 9 && !pws0) && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("abort_sync", 32'(idx0), 32'd9);
    repeat (10) @(posedge clk);
    #2; enable0 = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_sck", 32'(mic_clk0), 32'd0);
    check_eq("abort_ws", 32'(mic_ws0), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_partial", 32'(valid0), 32'd0);
    check_eq("abort_idle", 32'(mic_clk0), 32'd0);
    w0_l = 18'h3C3C3; p = pops0;
    enable0 = 1'b1;
    n = 0; while (pops0 == p && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("abort_full", 32'(pops0 - p), 32'd1);

    // Reset while a sample is held and overflow is set.
    auto0 = 1'b0; ready0 = 1'b0;
    n = 0; while (!valid0 && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("pre_rst_valid", 32'(valid0), 32'd1);
    n = 0; while (!ovf0 && n < 1100) begin @(posedge clk); #2; n++; end
    check_eq("pre_rst_ovf", 32'(ovf0), 32'd1);
    reset0 = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valid", 32'(valid0), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf0), 32'd0);
    check_eq("mid_rst_data", 32'(data0), 32'd0);
    check_eq("mid_rst_sck", 32'(mic_clk0), 32'd0);
    reset0 = 1'b0;

    check_eq("st_count", 32'(pops_st >= 10), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
